// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the FPU integer/float conversion paths.
//   i2f_state_t : int-to-float converter FSM states
//   EXP_BIAS    : binary32 exponent bias
//   EXP_INIT    : biased exponent of a magnitude with bit 31 set (127 + 31)
//   MANT_W/EXP_W: binary32 stored mantissa and exponent widths
package fpu_pkg;
    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} i2f_state_t;
    localparam int EXP_BIAS = 127;
    localparam int EXP_INIT = 158;
    localparam int MANT_W   = 23;
    localparam int EXP_W    = 8;
endpackage

// File: rtl/fpu_round_rne.sv
// fpu_round_rne: round-to-nearest-even of a normalised mantissa with guard/sticky bits.
//   mant/g/s/exp : truncated mantissa, guard bit, sticky bit, biased exponent
//   mant_r/exp_r : rounded mantissa and exponent (mantissa overflow bumps exponent)
//   inexact      : any discarded bit was nonzero
module fpu_round_rne
    import fpu_pkg::*;
(
    input  logic [MANT_W-1:0] mant,
    input  logic              g,
    input  logic              s,
    input  logic [EXP_W-1:0]  exp,
    output logic [MANT_W-1:0] mant_r,
    output logic [EXP_W-1:0]  exp_r,
    output logic              inexact
);
    logic            up;
    logic [MANT_W:0] sum;

    always_comb begin
        up      = g & (s | mant[0]);
        sum     = {1'b0, mant} + {{MANT_W{1'b0}}, up};
        // On carry-out the low bits are already zero, giving 1.0 x 2^(exp+1)
        mant_r  = sum[MANT_W-1:0];
        exp_r   = exp + {{(EXP_W-1){1'b0}}, sum[MANT_W]};
        inexact = g | s;
    end
endmodule

// File: rtl/fpu_int2float.sv
// fpu_int2float: sequential 32-bit signed/unsigned integer to binary32 converter.
//   clk, rst           : clock, synchronous active-high reset
//   in_valid/in_ready  : request handshake; in_ready high only when idle
//   in_data/in_signed  : integer operand and two's-complement select
//   out_valid/out_ready: result handshake; result held until consumed
//   out_data           : {sign, exp[7:0], mant[22:0]}
//   out_inexact        : rounding discarded a nonzero bit
module fpu_int2float
    import fpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_signed,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_inexact
);
    i2f_state_t        state_q, state_d;
    logic [31:0]       mag_q, mag_d;
    logic [EXP_W-1:0]  exp_q, exp_d;
    logic              sign_q, sign_d;
    logic [31:0]       out_data_q, out_data_d;
    logic              out_inexact_q, out_inexact_d;
    logic              in_neg;
    logic [31:0]       in_mag, mag_sh;
    logic [EXP_W-1:0]  exp_sh, exp_r;
    logic [MANT_W-1:0] mant_r;
    logic              inexact_r;

    fpu_round_rne u_round (
        .mant    (mag_q[30:8]),
        .g       (mag_q[7]),
        .s       (|mag_q[6:0]),
        .exp     (exp_q),
        .mant_r  (mant_r),
        .exp_r   (exp_r),
        .inexact (inexact_r)
    );

    always_comb begin
        in_neg        = in_signed & in_data[31];
        in_mag        = in_neg ? (~in_data + 32'd1) : in_data;
        mag_sh        = (mag_q[31:24] == 8'd0) ? (mag_q << 8) : (mag_q << 1);
        exp_sh        = (mag_q[31:24] == 8'd0) ? (exp_q - EXP_W'(8)) : (exp_q - EXP_W'(1));
        state_d       = state_q;
        mag_d         = mag_q;
        exp_d         = exp_q;
        sign_d        = sign_q;
        out_data_d    = out_data_q;
        out_inexact_d = out_inexact_q;
        case (state_q)
            IDLE: if (in_valid) begin
                sign_d = in_neg;
                mag_d  = in_mag;
                exp_d  = EXP_W'(EXP_INIT);
                if (in_mag == 32'd0) begin
                    out_data_d    = 32'd0;
                    out_inexact_d = 1'b0;
                    state_d       = DONE;
                end else begin
                    state_d = in_mag[31] ? ROUND : NORM;
                end
            end
            // Next state looks at the shifted value so the final shift hands
            // straight to ROUND without an extra idle NORM cycle.
            NORM: begin
                mag_d   = mag_sh;
                exp_d   = exp_sh;
                state_d = mag_sh[31] ? ROUND : NORM;
            end
            ROUND: begin
                out_data_d    = {sign_q, exp_r, mant_r};
                out_inexact_d = inexact_r;
                state_d       = DONE;
            end
            DONE: state_d = out_ready ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mag_q         <= '0;
            exp_q         <= '0;
            sign_q        <= 1'b0;
            out_data_q    <= '0;
            out_inexact_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            mag_q         <= mag_d;
            exp_q         <= exp_d;
            sign_q        <= sign_d;
            out_data_q    <= out_data_d;
            out_inexact_q <= out_inexact_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign out_data    = out_data_q;
    assign out_inexact = out_inexact_q;
endmodule
